// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of a 5-stage pipeline. Holds the fetch
//             PC, drives the instruction memory address combinationally and
//             registers the fetched word into the IF/ID pipeline register.
//             Handles hazard stalls, MEM-stage redirects (inserting a single
//             bubble), a one-cycle boot state after reset, a counter of
//             accepted instructions and a sticky misaligned-target flag.
//  Ports    :
//    clk            in   1   rising-edge clock
//    rst            in   1   synchronous active-high reset
//    stall          in   1   hazard hold request (freezes PC and IF/ID)
//    redirect       in   1   taken branch / jump from MEM stage
//    redirect_pc    in  32   redirect target address
//    imem_addr      out 32   instruction memory address (= pc)
//    imem_data      in  32   instruction word at imem_addr (same cycle)
//    pc             out 32   current fetch PC
//    if_id_inst     out 32   registered instruction for decode
//    if_id_pc_next  out 32   registered pc+4 of that instruction
//    if_id_valid    out  1   1 = if_id_inst is a real fetched instruction
//    fetch_state    out  2   BOOT=0, RUN=1, HOLD=2, SQUASH=3
//    fetch_count    out 32   instructions accepted into IF/ID (wraps)
//    misalign_err   out  1   sticky: a redirect target had bits[1:0] != 0
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_next,
  output logic        if_id_valid,
  output logic [1:0]  fetch_state,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SQUASH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;

  // Natural 32-bit add: 0xFFFF_FFFC + 4 wraps to 0 silently.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    // Default: everything holds.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_next_d  = pc_next_q;
    valid_d    = valid_q;
    count_d    = count_q;
    misalign_d = misalign_q;

    case (state_q)
      // Boot lasts exactly one cycle and ignores stall/redirect so the
      // first fetch always starts cleanly from RESET_PC.
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      default: begin
        if (redirect) begin
          // Low address bits are dropped; a misaligned target is only
          // reported, never trapped. IF/ID becomes a bubble, which also
          // discards any instruction held there by a concurrent stall.
          pc_d       = {redirect_pc[31:2], 2'b00};
          inst_d     = NOP_INST;
          valid_d    = 1'b0;
          state_d    = ST_SQUASH;
          misalign_d = misalign_q | (|redirect_pc[1:0]);
        end else if (stall) begin
          state_d = ST_HOLD;
        end else begin
          pc_d      = pc_plus4;
          inst_d    = imem_data;
          pc_next_d = pc_plus4;
          valid_d   = 1'b1;
          count_d   = count_q + 32'd1;
          state_d   = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_next_q  <= 32'h0000_0000;
      valid_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_next_q  <= pc_next_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign if_id_inst    = inst_q;
  assign if_id_pc_next = pc_next_q;
  assign if_id_valid   = valid_q;
  assign fetch_state   = state_q;
  assign fetch_count   = count_q;
  assign misalign_err  = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. Instruction memory is a
//             combinational model returning (addr | 0xC0DE_0000), so every
//             expected instruction word can be worked out by hand from the
//             PC. A table of per-cycle inputs and expected post-edge outputs
//             is applied in a loop, followed by hand-written sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] C_NOP  = 32'h0000_0013;
  localparam logic [31:0] C_RPC  = 32'h0000_0000;
  localparam logic [31:0] C_TAG  = 32'hC0DE_0000;

  localparam logic [1:0] C_BOOT = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_HOLD = 2'd2;
  localparam logic [1:0] C_SQ   = 2'd3;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_next;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int n_checks;
  int n_fail;

  fetch_stage #(
    .RESET_PC (C_RPC),
    .NOP_INST (C_NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_inst    (if_id_inst),
    .if_id_pc_next (if_id_pc_next),
    .if_id_valid   (if_id_valid),
    .fetch_state   (fetch_state),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory model.
  assign imem_data = imem_addr | C_TAG;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pcn;
    logic        e_valid;
    logic [1:0]  e_state;
    logic [31:0] e_count;
    logic        e_mis;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_pcn, input logic e_valid, input logic [1:0] e_state,
                           input logic [31:0] e_count, input logic e_mis);
    chk32({tag, " pc"},        pc,                    e_pc);
    chk32({tag, " imem_addr"}, imem_addr,             e_pc);
    chk32({tag, " inst"},      if_id_inst,            e_inst);
    chk32({tag, " pc_next"},   if_id_pc_next,         e_pcn);
    chk32({tag, " valid"},     {31'd0, if_id_valid},  {31'd0, e_valid});
    chk32({tag, " state"},     {30'd0, fetch_state},  {30'd0, e_state});
    chk32({tag, " count"},     fetch_count,           e_count);
    chk32({tag, " misalign"},  {31'd0, misalign_err}, {31'd0, e_mis});
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rp);
    @(negedge clk);
    rst         = r;
    stall       = s;
    redirect    = d;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] rp,
                              input logic [31:0] pc_e, input logic [31:0] inst_e,
                              input logic [31:0] pcn_e, input logic v_e, input logic [1:0] st_e,
                              input logic [31:0] cnt_e, input logic mis_e);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = d; v.rpc = rp;
    v.e_pc = pc_e; v.e_inst = inst_e; v.e_pcn = pcn_e; v.e_valid = v_e;
    v.e_state = st_e; v.e_count = cnt_e; v.e_mis = mis_e;
    return v;
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    //            rst s  d  redirect_pc    pc             inst           pc_next        v  state   count mis
    vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,         C_NOP,         32'h0,         0, C_BOOT, 0, 0);
    // Boot ignores stall and redirect.
    vecs[1]  = mk(0, 1, 1, 32'h800,       32'h0,         C_NOP,         32'h0,         0, C_RUN,  0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         32'h4,         32'hC0DE_0000, 32'h4,         1, C_RUN,  1, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         32'h8,         32'hC0DE_0004, 32'h8,         1, C_RUN,  2, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         32'hC,         32'hC0DE_0008, 32'hC,         1, C_RUN,  3, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         32'h10,        32'hC0DE_000C, 32'h10,        1, C_RUN,  4, 0);
    // Two-cycle stall at pc=0x10.
    vecs[6]  = mk(0, 1, 0, 32'h0,         32'h10,        32'hC0DE_000C, 32'h10,        1, C_HOLD, 4, 0);
    vecs[7]  = mk(0, 1, 0, 32'h0,         32'h10,        32'hC0DE_000C, 32'h10,        1, C_HOLD, 4, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,         32'h14,        32'hC0DE_0010, 32'h14,        1, C_RUN,  5, 0);
    // Redirect with concurrent stall: redirect wins, pc_next holds.
    vecs[9]  = mk(0, 1, 1, 32'h400,       32'h400,       C_NOP,         32'h14,        0, C_SQ,   5, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,         32'h404,       32'hC0DE_0400, 32'h404,       1, C_RUN,  6, 0);
    // Misaligned target, then held redirects keep reloading pc.
    vecs[11] = mk(0, 0, 1, 32'h402,       32'h400,       C_NOP,         32'h404,       0, C_SQ,   6, 1);
    vecs[12] = mk(0, 0, 1, 32'h200,       32'h200,       C_NOP,         32'h404,       0, C_SQ,   6, 1);
    vecs[13] = mk(0, 0, 1, 32'h300,       32'h300,       C_NOP,         32'h404,       0, C_SQ,   6, 1);
    vecs[14] = mk(0, 0, 0, 32'h0,         32'h304,       32'hC0DE_0300, 32'h304,       1, C_RUN,  7, 1);
    // PC wrap.
    vecs[15] = mk(0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, C_NOP,         32'h304,       0, C_SQ,   7, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, C_RUN,  8, 1);
    vecs[17] = mk(0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1, C_RUN,  9, 1);
    // Stall, then reset arrives mid-stall with a pending misaligned redirect.
    vecs[18] = mk(0, 1, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1, C_HOLD, 9, 1);
    vecs[19] = mk(0, 1, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1, C_HOLD, 9, 1);
    vecs[20] = mk(1, 1, 1, 32'h501,       32'h0,         C_NOP,         32'h0,         0, C_BOOT, 0, 0);
    vecs[21] = mk(0, 1, 1, 32'h600,       32'h0,         C_NOP,         32'h0,         0, C_RUN,  0, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,         32'h4,         32'hC0DE_0000, 32'h4,         1, C_RUN,  1, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pcn,
                vecs[i].e_valid, vecs[i].e_state, vecs[i].e_count, vecs[i].e_mis);
    end

    // Redirect followed by a stall in the next cycle: the bubble persists
    // until the stall drops, then the target instruction arrives.
    step(0, 0, 1, 32'h700);
    check_all("sq_stall_a", 32'h700, C_NOP, 32'h4, 0, C_SQ, 1, 0);
    step(0, 1, 0, 32'h0);
    check_all("sq_stall_b", 32'h700, C_NOP, 32'h4, 0, C_HOLD, 1, 0);
    step(0, 0, 0, 32'h0);
    check_all("sq_stall_c", 32'h704, 32'hC0DE_0700, 32'h704, 1, C_RUN, 2, 0);

    // Redirect issued from HOLD; aligned target leaves misalign clear.
    step(0, 1, 0, 32'h0);
    check_all("hold_rd_a", 32'h704, 32'hC0DE_0700, 32'h704, 1, C_HOLD, 2, 0);
    step(0, 1, 1, 32'h1000);
    check_all("hold_rd_b", 32'h1000, C_NOP, 32'h704, 0, C_SQ, 2, 0);
    step(0, 0, 0, 32'h0);
    check_all("hold_rd_c", 32'h1004, 32'hC0DE_1000, 32'h1004, 1, C_RUN, 3, 0);

    // Reset while a redirect is being asserted.
    step(1, 0, 1, 32'h2003);
    check_all("rst_rd", 32'h0, C_NOP, 32'h0, 0, C_BOOT, 0, 0);
    step(0, 0, 0, 32'h0);
    check_all("rst_rd_boot", 32'h0, C_NOP, 32'h0, 0, C_RUN, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000: instruction word injected into IF/ID on bubbles.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port stall  input  1  hazard hold request; freezes PC and IF/ID.
REQ-006 Port redirect  input  1  taken branch or jump from MEM stage.
REQ-007 Port redirect_pc  input  32  redirect target address.
REQ-008 Port imem_addr  output  32  instruction memory address, combinational copy of pc.
REQ-009 Port imem_data  input  32  instruction word at imem_addr, combinational read, same cycle.
REQ-010 Port pc  output  32  current fetch PC register.
REQ-011 Port if_id_inst  output  32  registered instruction to decode.
REQ-012 Port if_id_pc_next  output  32  registered pc+4 of that instruction.
REQ-013 Port if_id_valid  output  1  registered; 1 = if_id_inst is a real fetched instruction.
REQ-014 Port fetch_state  output  2  FSM state: BOOT=0, RUN=1, HOLD=2, SQUASH=3.
REQ-015 Port fetch_count  output  32  number of instructions accepted into IF/ID.
REQ-016 Port misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-017 imem_addr SHALL equal pc at all times, with no register stage.
REQ-018 The FSM SHALL leave BOOT after exactly one cycle, unconditionally; stall and redirect are ignored in BOOT, and pc, IF/ID and fetch_count hold.
REQ-019 Outside BOOT, event priority SHALL be rst > redirect > stall > normal fetch, evaluated each rising edge.
REQ-020 Redirect: pc <= {redirect_pc[31:2],2'b00}; if_id_inst <= NOP_INST; if_id_valid <= 0; if_id_pc_next holds; state <= SQUASH; fetch_count holds.
REQ-021 Redirect with redirect_pc[1:0] != 0 SHALL set misalign_err; misalign_err clears only on rst.
REQ-022 Stall without redirect: pc, if_id_inst, if_id_pc_next, if_id_valid and fetch_count hold; state <= HOLD.
REQ-023 Normal fetch: pc <= pc+4; if_id_inst <= imem_data; if_id_pc_next <= pc+4; if_id_valid <= 1; fetch_count <= fetch_count+1; state <= RUN.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-025 fetch_count SHALL wrap modulo 2^32 (32'hFFFF_FFFF -> 0) with no flag.
REQ-026 Redirect and stall asserted together: redirect wins; the stalled instruction in IF/ID is discarded.
REQ-027 Latency: an instruction present on imem_data in cycle N SHALL appear on if_id_inst in cycle N+1.
REQ-028 Redirect asserted in cycle N: the target instruction SHALL appear valid on IF/ID at N+2, provided no stall occurs in N+1; exactly one bubble is inserted.
REQ-029 Redirect held across consecutive cycles SHALL reload pc each cycle, and IF/ID stays a bubble.

Reset
REQ-030 rst high at a rising edge SHALL set pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc_next=0, if_id_valid=0, fetch_count=0, misalign_err=0, state=BOOT, overriding all other inputs.
REQ-031 rst asserted mid-stall or mid-redirect SHALL abandon the operation; no pending state survives reset.
REQ-032 All outputs SHALL reach their reset values one edge after rst is sampled high.

Verification
REQ-033 Reset then free-run, imem_data=pc-derived pattern: BOOT for 1 cycle; then pc steps 0,4,8; if_id_inst follows pc one cycle later; fetch_count=3 after 3 RUN cycles.
REQ-034 Stall for 2 cycles with pc=0x10: pc stays 0x10, IF/ID unchanged, state=HOLD, count frozen; on release pc=0x14 on the next edge.
REQ-035 Redirect to 0x400 with stall=1 in the same cycle: pc=0x400, if_id_valid=0, state=SQUASH; next cycle if_id_inst=imem[0x400], valid=1.
REQ-036 Redirect to 0x402: pc=0x400 and misalign_err=1; misalign_err stays 1 through later redirects; cleared by rst.
REQ-037 Wrap cases: pc preset near 0xFFFF_FFFC steps to 0; fetch_count at 0xFFFF_FFFF wraps to 0 on the next fetch.
REQ-038 rst during a 3-cycle stall with a pending redirect: all outputs equal REQ-030 values; state=BOOT, then RUN from RESET_PC.
